instr_loader: RTL
=================

Name: instr_loader

Overview:
- Writer side of the 256x16 instruction memory that the fetch path reads.
- Accepts decoded instruction fields over a valid/ready stream and packs each one into the 16-bit instruction format.
- Writes packed words sequentially from address 0, then reads the program back through the same synchronous memory port and checks a 16-bit checksum.
- Sits between the program source (testbench, host, or boot sequencer) and the memory write port; the core is held off until done.

Parameters:
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of instruction words; must equal 2**ADDR_W.
- VERIFY, 1, 1 = readback checksum pass after load; 0 = skip straight to DONE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_op  in  4  opcode.
- in_rs  in  2  source register.
- in_rt  in  2  target register.
- in_rd  in  2  destination register.
- in_imm  in  8  immediate.
- in_fmt  in  1  0 = R-format, 1 = I-format.
- in_last  in  1  marks final instruction of the program.
- mem_addr  out  ADDR_W  memory address, used for both write and read.
- mem_wdata  out  16  packed instruction word.
- mem_wren  out  1  write enable.
- mem_q  in  16  memory read data, valid one clk after mem_addr is presented.
- busy  out  1  session in progress.
- done  out  1  session complete; sticky until next start.
- err  out  1  checksum mismatch; sticky until next start.
- word_count  out  ADDR_W+1  number of words written this session.

Behaviour:
- Packing: word[15:12]=op, [11:10]=rs, [9:8]=rt.
  - R-format: [7:0]={rd,6'b0}.
  - I-format: [7:0]=imm; rd is ignored.
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: in_ready, mem_wren, mem_addr, mem_wdata, busy, done, err, word_count.
  - Internal wr_ptr, rd_ptr and checksums cleared.
  - Reset mid-session aborts immediately; mem_wren drops with no further writes.
- States: IDLE, LOAD, VERIFY, CHECK, DONE.
- IDLE/DONE:
  - start=1 -> LOAD next cycle; clears done, err, word_count, wr_ptr and sums; busy=1.
  - start while busy is ignored.
- LOAD:
  - in_ready=1 in LOAD only.
  - Transfer occurs when in_valid&in_ready at edge t.
  - At t+1: mem_wren=1, mem_addr=wr_ptr, mem_wdata=packed word, wr_ptr++, word_count++, wsum+=word (mod 2^16).
  - mem_wren is 0 on cycles with no transfer; gaps in in_valid are legal.
- Leaving LOAD:
  - A transfer with in_last=1, or a transfer at wr_ptr=DEPTH-1 (overflow guard, word_count=DEPTH), is the final one.
  - in_ready drops the cycle after the final transfer; further bundles are not accepted.
  - The final write still completes.
  - Next state is VERIFY if VERIFY=1, else DONE.
- VERIFY:
  - mem_wren=0; mem_addr=rd_ptr starting at 0 and incrementing each cycle until word_count-1.
  - mem_q for address k is sampled the cycle after k is presented: rsum+=mem_q.
  - After the last sample -> CHECK.
- CHECK (1 cycle): err<=(rsum!=wsum) -> DONE.
- DONE: busy=0, done=1; word_count held.
- Timing: VERIFY+CHECK takes word_count+2 cycles.
- Empty program is impossible: the first accepted word may carry in_last; word_count is then 1.
- wr_ptr wraps never; the overflow guard stops LOAD at DEPTH.

Test Plan:
- R-format: start, bundle op=4'h3, rs=1, rt=2, rd=3, fmt=0, last=1 -> cycle after accept: mem_wren=1, mem_addr=0, mem_wdata=16'h36C0. Then 1 verify read, done=1, err=0, word_count=1.
- I-format with backpressure: 3 bundles, second preceded by 2 idle in_valid cycles; third is op=4'hA, rs=0, rt=1, imm=8'h5F, last=1.
  - Writes land at addr 0,1,2 only on accept cycles; addr 2 data=16'hA15F.
  - Bundle presented after last gets no in_ready.
- Verify mismatch: memory model returns word^16'h0001 at addr 1 during VERIFY -> err=1, done=1.
  - Next start clears err and done.
- Overflow: 300 bundles, none with last -> exactly 256 writes (addr 0..255), in_ready falls after the 256th, word_count=256, err=0.
- Reset mid-LOAD: rst_n low after 5 writes -> mem_wren=0 and all outputs 0 asynchronously.
  - New start writes from addr 0; word_count restarts at 0.
- start pulsed during VERIFY is ignored; with VERIFY=0, done rises 1 cycle after the final write with no read addresses issued.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: packs decoded instruction fields into 16-bit words, writes
// them sequentially into the instruction memory from address 0, then
// optionally reads the program back and compares a 16-bit checksum.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for start after reset
//   S_LOAD   | accepting bundles; r_final marks the last write in flight
//   S_VERIFY | issuing read addresses 0..word_count-1, summing mem_q
//   S_CHECK  | compare read-back sum with write sum
//   S_DONE   | session complete, results held until next start
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [1:0]        in_rs,
    input  logic [1:0]        in_rt,
    input  logic [1:0]        in_rd,
    input  logic [7:0]        in_imm,
    input  logic              in_fmt,
    input  logic              in_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_wren,
    input  logic [15:0]       mem_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Pointer value at which the write fills the last memory slot.
    localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(DEPTH - 1);

    logic [2:0]        r_state;
    logic              r_final;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [15:0]       r_wsum;
    logic [15:0]       r_rsum;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_mem_wren;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [15:0]       w_word;
    logic              w_in_ready;
    logic              w_xfer;
    logic [ADDR_W:0]   w_rd_nxt;

    // Field packing and handshake; in_ready drops as soon as the final
    // bundle has been taken, while its write is still on the memory port.
    always_comb begin
        w_word     = {in_op, in_rs, in_rt, (in_fmt ? in_imm : {in_rd, 6'b0})};
        w_in_ready = (r_state == S_LOAD) && !r_final;
        w_xfer     = in_valid && w_in_ready;
        w_rd_nxt   = r_rd_ptr + 1'b1;
    end

    // Session sequencing, memory port drive and checksum accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_final     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wsum      <= '0;
            r_rsum      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_wren <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_err    <= 1'b0;
                        r_final  <= 1'b0;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_wsum   <= '0;
                        r_rsum   <= '0;
                    end
                end
                S_LOAD: begin
                    if (r_final) begin
                        // Final write completed on the port during this cycle.
                        if (VERIFY != 0) begin
                            r_state    <= S_VERIFY;
                            r_mem_addr <= '0;
                            r_rd_ptr   <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_xfer) begin
                        r_mem_wren  <= 1'b1;
                        r_mem_addr  <= r_wr_ptr[ADDR_W-1:0];
                        r_mem_wdata <= w_word;
                        r_wr_ptr    <= r_wr_ptr + 1'b1;
                        r_wsum      <= r_wsum + w_word;
                        if (in_last || (r_wr_ptr == LP_LAST)) begin
                            r_final <= 1'b1;
                        end
                    end
                end
                S_VERIFY: begin
                    // r_rd_ptr counts VERIFY cycles; from the second one on,
                    // mem_q holds the word for the address presented before.
                    if (r_rd_ptr != '0) begin
                        r_rsum <= r_rsum + mem_q;
                    end
                    if (r_rd_ptr == r_wr_ptr) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_rd_ptr <= w_rd_nxt;
                        if (w_rd_nxt < r_wr_ptr) begin
                            r_mem_addr <= w_rd_nxt[ADDR_W-1:0];
                        end
                    end
                end
                S_CHECK: begin
                    r_err   <= (r_rsum != r_wsum);
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wren   = r_mem_wren;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_wr_ptr;

endmodule
